fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage for the 8-bit processor. Holds the architectural PC, requests the instruction at PC from instruction memory with a req/ack handshake, and presents the fetched word downstream with a valid/ready handshake. When the downstream stage accepts an instruction, the unit loads the PC from `next_addr`, the branch/jump target resolver's output. It is the consumer of that resolver: the resolver decides the address, this block applies it and fetches.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: fetch FSM states, default widths
// and the opcode field layout used by fetch, resolver and decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_CNT_W   = 16;

  // Opcode is the top OP_W bits of the instruction; the resolver only needs
  // the upper OP_TAG_W of those (opcode without its LSB).
  localparam int OP_W     = 6;
  localparam int OP_TAG_W = 5;

endpackage

// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch stage: fetches the word at pc over a
// req/ack memory handshake and issues it downstream over valid/ready.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   next_addr,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [OP_TAG_W-1:0] op,
  output logic [ADDR_W-1:0]   pc,
  output logic [CNT_W-1:0]    retired
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   retired_q;
  logic [CNT_W-1:0]   retired_d;
  logic               imem_req_q;
  logic               instr_valid_q;

  // Retired count wraps naturally modulo 2^CNT_W.
  always_comb begin
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Fetch FSM; req/valid are registered alongside the state so they never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RESET;
      pc_q          <= {ADDR_W{1'b0}};
      instr_q       <= {INSTR_W{1'b0}};
      retired_q     <= {CNT_W{1'b0}};
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          state_q       <= FETCH;
          imem_req_q    <= 1'b1;
          instr_valid_q <= 1'b0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            state_q       <= ISSUE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else begin
            state_q       <= FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        ISSUE: begin
          // next_addr is sampled only on the accept edge.
          if (instr_ready) begin
            pc_q          <= next_addr;
            retired_q     <= retired_d;
            state_q       <= FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end else begin
            state_q       <= ISSUE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= RESET;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[INSTR_W-1 -: OP_TAG_W];
  assign pc          = pc_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, sequential run, jump,
// wrap, memory/downstream stalls, spurious ack and mid-fetch reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  next_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [4:0]  op;
  logic [7:0]  pc;
  logic [15:0] retired;

  int n_vec;
  int n_miscompare;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .next_addr  (next_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .op         (op),
    .pc         (pc),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miscompare = n_miscompare + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sampling and driving happen at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},     {31'd0, imem_req},    32'd0);
    chk({tag, ".valid"},   {31'd0, instr_valid}, 32'd0);
    chk({tag, ".pc"},      {24'd0, pc},          32'd0);
    chk({tag, ".instr"},   {16'd0, instr},       32'd0);
    chk({tag, ".op"},      {27'd0, op},          32'd0);
    chk({tag, ".retired"}, {16'd0, retired},     32'd0);
  endtask

  // From ISSUE: accept with target nxt, then fetch data with a zero-wait ack.
  task automatic accept_fetch(input logic [7:0] nxt, input logic [15:0] data,
                              input logic [15:0] exp_ret);
    instr_ready = 1'b1;
    next_addr   = nxt;
    step();
    instr_ready = 1'b0;
    chk("acc.req",     {31'd0, imem_req},    32'd1);
    chk("acc.valid",   {31'd0, instr_valid}, 32'd0);
    chk("acc.addr",    {24'd0, imem_addr},   {24'd0, nxt});
    chk("acc.retired", {16'd0, retired},     {16'd0, exp_ret});
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
    chk("iss.valid", {31'd0, instr_valid}, 32'd1);
    chk("iss.req",   {31'd0, imem_req},    32'd0);
    chk("iss.instr", {16'd0, instr},       {16'd0, data});
    chk("iss.pc",    {24'd0, pc},          {24'd0, nxt});
  endtask

  initial begin
    n_vec        = 0;
    n_miscompare = 0;
    rst          = 1'b1;
    next_addr    = 8'h00;
    imem_ack     = 1'b0;
    imem_rdata   = 16'h0000;
    instr_ready  = 1'b0;
    step();
    step();
    chk_reset_vals("rst");

    // Release: request at 0x00 one cycle later, zero-wait ack with 0xA5C3.
    rst = 1'b0;
    step();
    chk("rel.req",  {31'd0, imem_req},  32'd1);
    chk("rel.addr", {24'd0, imem_addr}, 32'h00);
    imem_ack   = 1'b1;
    imem_rdata = 16'hA5C3;
    step();
    imem_ack = 1'b0;
    chk("first.valid", {31'd0, instr_valid}, 32'd1);
    chk("first.instr", {16'd0, instr},       32'hA5C3);
    chk("first.op",    {27'd0, op},          32'h14);
    chk("first.req",   {31'd0, imem_req},    32'd0);

    // Sequential run: one instruction per two cycles, retired counts accepts.
    for (int i = 1; i <= 4; i++) begin
      accept_fetch(8'(i), 16'h1000 + 16'(i), 16'(i));
    end

    // Jump from 0x10 to 0x40, then wrap 0xFF -> 0x00.
    accept_fetch(8'h10, 16'h1111, 16'd5);
    accept_fetch(8'h40, 16'h2222, 16'd6);
    accept_fetch(8'hFF, 16'h3333, 16'd7);
    accept_fetch(8'h00, 16'h4444, 16'd8);
    chk("wrap.op", {27'd0, op}, 32'h08);

    // Downstream stall for 5 cycles with moving next_addr and spurious acks.
    for (int i = 0; i < 5; i++) begin
      next_addr  = 8'h55 + 8'(i);
      imem_ack   = 1'b1;
      imem_rdata = 16'hDEAD;
      step();
      chk("stall.valid",   {31'd0, instr_valid}, 32'd1);
      chk("stall.req",     {31'd0, imem_req},    32'd0);
      chk("stall.instr",   {16'd0, instr},       32'h4444);
      chk("stall.pc",      {24'd0, pc},          32'h00);
      chk("stall.retired", {16'd0, retired},     32'd8);
    end
    imem_ack = 1'b0;

    // Accept to 0x20, then memory ack delayed 3 cycles: 4 stable request cycles.
    instr_ready = 1'b1;
    next_addr   = 8'h20;
    step();
    instr_ready = 1'b0;
    next_addr   = 8'h77;
    chk("mw.req0",     {31'd0, imem_req},  32'd1);
    chk("mw.addr0",    {24'd0, imem_addr}, 32'h20);
    chk("mw.retired",  {16'd0, retired},   32'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mw.req",   {31'd0, imem_req},    32'd1);
      chk("mw.addr",  {24'd0, imem_addr},   32'h20);
      chk("mw.valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 16'h5A5A;
    step();
    imem_ack = 1'b0;
    chk("mw.ivalid", {31'd0, instr_valid}, 32'd1);
    chk("mw.instr",  {16'd0, instr},       32'h5A5A);

    // Reset during FETCH with an ack pending, then a late ack while in RESET.
    instr_ready = 1'b1;
    next_addr   = 8'h30;
    step();
    instr_ready = 1'b0;
    chk("pre.addr", {24'd0, imem_addr}, 32'h30);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    step();
    imem_ack = 1'b0;
    chk("late.instr", {16'd0, instr},       32'h0000);
    chk("late.req",   {31'd0, imem_req},    32'd1);
    chk("late.addr",  {24'd0, imem_addr},   32'h00);
    chk("late.valid", {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0F0F;
    step();
    imem_ack = 1'b0;
    chk("restart.valid",   {31'd0, instr_valid}, 32'd1);
    chk("restart.instr",   {16'd0, instr},       32'h0F0F);
    chk("restart.pc",      {24'd0, pc},          32'h00);
    chk("restart.retired", {16'd0, retired},     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
